stopwatch_run_controller: RTL and testbench

Synchronous run/lap/pause/clear controller for the stopwatch counter: debounces the two push-buttons, sequences counting through a clock-enable rather than a gated clock, and freezes a display snapshot for split (lap) times. It sits between the board buttons and the stopwatch counter/display path, all in the `CLK_100Hz` domain. It also traps counter overflow until the user clears it.

---
 rtl/stopwatch_run_controller.sv | 140 ++++++++++++++
 tb/tb_stopwatch_run_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_run_controller.sv
// Stopwatch run/lap/pause/clear sequencer: debounced buttons drive a clock-enable FSM, lap snapshots and an overflow trap.
// Latency: button to state is DEBOUNCE_TICKS+2 cycles; outputs are registered from next state; no backpressure (runs every cycle).
module stopwatch_run_controller #(
  parameter int unsigned DEBOUNCE_TICKS = 2
) (
  input  logic       CLK_100Hz,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       hold,
  input  logic       overflow,
  input  logic [6:0] cnt_mins,
  input  logic [5:0] cnt_secs,
  input  logic [6:0] cnt_decs,
  output logic       count_en,
  output logic       counter_clear,
  output logic       display_freeze,
  output logic       ovf_flag,
  output logic [2:0] state,
  output logic [6:0] disp_mins,
  output logic [5:0] disp_secs,
  output logic [6:0] disp_decs
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    LAP       = 3'd2,
    PAUSE     = 3'd3,
    LAP_PAUSE = 3'd4,
    OVF       = 3'd5
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_TICKS - 1);

  // Bit 0 carries start_stop, bit 1 carries hold through every stage.
  logic [1:0]      btn_s1;
  logic [1:0]      btn_s2;
  logic [1:0]      btn_db;
  logic [1:0]      btn_db_d;
  logic [1:0][7:0] db_cnt;
  logic [1:0]      press;
  logic            ss_ev;
  logic            hd_ev;

  state_t cur_st;
  state_t nxt_st;
  logic   clr_nxt;
  logic   freeze_nxt;

  always_ff @(posedge CLK_100Hz or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_db   <= '0;
      btn_db_d <= '0;
      db_cnt   <= '0;
    end else begin
      btn_s1   <= {hold, start_stop};
      btn_s2   <= btn_s1;
      btn_db_d <= btn_db;
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_db[i] <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign press = btn_db & ~btn_db_d;
  assign ss_ev = press[0];
  assign hd_ev = press[1];

  // Overflow beats buttons while counting; start_stop beats hold otherwise.
  always_comb begin
    nxt_st  = cur_st;
    clr_nxt = 1'b0;
    if (overflow && (cur_st == RUN || cur_st == LAP)) begin
      nxt_st = OVF;
    end else begin
      case (cur_st)
        IDLE:      if (ss_ev) nxt_st = RUN;
        RUN:       if (ss_ev) nxt_st = PAUSE;
                   else if (hd_ev) nxt_st = LAP;
        LAP:       if (ss_ev) nxt_st = LAP_PAUSE;
                   else if (hd_ev) nxt_st = RUN;
        PAUSE:     if (ss_ev) nxt_st = RUN;
                   else if (hd_ev) begin
                     nxt_st  = IDLE;
                     clr_nxt = 1'b1;
                   end
        LAP_PAUSE: if (ss_ev) nxt_st = LAP;
                   else if (hd_ev) nxt_st = PAUSE;
        OVF:       if (hd_ev && !ss_ev) begin
                     nxt_st  = IDLE;
                     clr_nxt = 1'b1;
                   end
        default:   nxt_st = IDLE;
      endcase
    end
  end

  assign freeze_nxt = (nxt_st == LAP) || (nxt_st == LAP_PAUSE);

  always_ff @(posedge CLK_100Hz or negedge reset_n) begin
    if (!reset_n) begin
      cur_st         <= IDLE;
      count_en       <= 1'b0;
      counter_clear  <= 1'b0;
      display_freeze <= 1'b0;
      ovf_flag       <= 1'b0;
      disp_mins      <= '0;
      disp_secs      <= '0;
      disp_decs      <= '0;
    end else begin
      cur_st         <= nxt_st;
      count_en       <= (nxt_st == RUN) || (nxt_st == LAP);
      counter_clear  <= clr_nxt;
      display_freeze <= freeze_nxt;
      ovf_flag       <= (nxt_st == OVF);
      // Snapshot taken on the edge that enters the frozen pair, then held.
      if (clr_nxt) begin
        disp_mins <= '0;
        disp_secs <= '0;
        disp_decs <= '0;
      end else if (!(freeze_nxt && display_freeze)) begin
        disp_mins <= cnt_mins;
        disp_secs <= cnt_secs;
        disp_decs <= cnt_decs;
      end
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_stopwatch_run_controller.sv
// Randomized bench: per-cycle reference model pushes expected outputs, a monitor pops and compares after each edge.
module tb_stopwatch_run_controller;

  localparam int DT = 2;

  logic       CLK_100Hz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       start_stop = 1'b0;
  logic       hold       = 1'b0;
  logic       overflow   = 1'b0;
  logic [6:0] cnt_mins   = '0;
  logic [5:0] cnt_secs   = '0;
  logic [6:0] cnt_decs   = '0;
  logic       count_en;
  logic       counter_clear;
  logic       display_freeze;
  logic       ovf_flag;
  logic [2:0] state;
  logic [6:0] disp_mins;
  logic [5:0] disp_secs;
  logic [6:0] disp_decs;

  always #5 CLK_100Hz = ~CLK_100Hz;

  stopwatch_run_controller #(.DEBOUNCE_TICKS(DT)) dut (
    .CLK_100Hz      (CLK_100Hz),
    .reset_n        (reset_n),
    .start_stop     (start_stop),
    .hold           (hold),
    .overflow       (overflow),
    .cnt_mins       (cnt_mins),
    .cnt_secs       (cnt_secs),
    .cnt_decs       (cnt_decs),
    .count_en       (count_en),
    .counter_clear  (counter_clear),
    .display_freeze (display_freeze),
    .ovf_flag       (ovf_flag),
    .state          (state),
    .disp_mins      (disp_mins),
    .disp_secs      (disp_secs),
    .disp_decs      (disp_decs)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ce;
    logic       clr;
    logic       frz;
    logic       ovf;
    logic [6:0] m;
    logic [5:0] s;
    logic [6:0] d;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;
  bit   done = 0;

  // Reference model: user-level meaning of each button, states 0..5 as numbered.
  int ss_tab[6] = '{1, 3, 4, 1, 2, 5};
  int hd_tab[6] = '{0, 2, 1, 0, 3, 0};
  bit   m_s1[2], m_s2[2], m_db[2], m_dbd[2];
  int   m_run[2];
  int   m_st;
  obs_t m_out;

  function automatic bit frozen(int s);
    return (s == 2) || (s == 4);
  endfunction

  task automatic model_step(input bit rst);
    bit ss, hd, clr;
    int nst;
    bit raw[2];
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_dbd[b] = 0; m_run[b] = 0;
      end
      m_st  = 0;
      m_out = '0;
    end else begin
      ss  = m_db[0] && !m_dbd[0];
      hd  = m_db[1] && !m_dbd[1];
      nst = m_st;
      clr = 0;
      if (overflow && (m_st == 1 || m_st == 2)) nst = 5;
      else if (ss) nst = ss_tab[m_st];
      else if (hd) begin
        nst = hd_tab[m_st];
        clr = (nst == 0) && (m_st != 0);
      end
      if (clr) begin
        m_out.m = 0; m_out.s = 0; m_out.d = 0;
      end else if (!(frozen(m_st) && frozen(nst))) begin
        m_out.m = cnt_mins; m_out.s = cnt_secs; m_out.d = cnt_decs;
      end
      m_out.st  = 3'(nst);
      m_out.ce  = (nst == 1) || (nst == 2);
      m_out.clr = clr;
      m_out.frz = frozen(nst);
      m_out.ovf = (nst == 5);
      m_st = nst;
      // A level is accepted after DT consecutive synchronized samples disagree with it.
      raw[0] = start_stop;
      raw[1] = hold;
      for (int b = 0; b < 2; b++) begin
        m_dbd[b] = m_db[b];
        if (m_s2[b] != m_db[b]) begin
          m_run[b]++;
          if (m_run[b] == DT) begin
            m_db[b]  = m_s2[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
    exp_q.push_back(m_out);
  endtask

  bit rst_drive = 1;

  task automatic cyc(input bit ss, input bit hd, input bit ov);
    @(negedge CLK_100Hz);
    reset_n    = !rst_drive;
    start_stop = ss;
    hold       = hd;
    overflow   = ov;
    cnt_mins   = 7'($urandom_range(0, 99));
    cnt_secs   = 6'($urandom_range(0, 59));
    cnt_decs   = 7'($urandom_range(0, 99));
    model_step(rst_drive);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  // which: 0 start_stop, 1 hold, 2 both
  task automatic press(input int which);
    for (int i = 0; i < DT + 4; i++) cyc(which != 1, which != 0, 0);
    idle(DT + 4);
  endtask

  task automatic async_reset_check();
    obs_t got;
    @(negedge CLK_100Hz);
    reset_n   = 0;
    rst_drive = 1;
    model_step(1);
    #1;
    got = {state, count_en, counter_clear, display_freeze, ovf_flag, disp_mins, disp_secs, disp_decs};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", got);
    end
  endtask

  initial begin : monitor
    obs_t got, exp;
    wait (exp_q.size() > 0);
    while (!done) begin
      @(posedge CLK_100Hz);
      #1;
      if (!done) begin
        cycle_no++;
        got = {state, count_en, counter_clear, display_freeze, ovf_flag, disp_mins, disp_secs, disp_decs};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL no_expectation cycle %0d: got %h required a queued value", cycle_no, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp)  begin
            errors++;
            $display("FAIL outputs cycle %0d: got st=%0d ce=%b clr=%b frz=%b ovf=%b disp=%0d/%0d/%0d required st=%0d ce=%b clr=%b frz=%b ovf=%b disp=%0d/%0d/%0d",
                     cycle_no, got.st, got.ce, got.clr, got.frz, got.ovf, got.m, got.s, got.d,
                     exp.st, exp.ce, exp.clr, exp.frz, exp.ovf, exp.m, exp.s, exp.d);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int lvl[2];
    int left[2];
    bit ovv;
    rst_drive = 1;
    idle(3);
    rst_drive = 0;
    idle(2);
    // Held start: one event, RUN after DT+2 edges; then a short glitch.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);
    idle(6);
    cyc(1, 0, 0);
    idle(6);
    press(1); idle(6); press(1);          // RUN -> LAP (frozen) -> RUN
    press(0); press(1); press(1);         // PAUSE -> IDLE with clear, hold in IDLE ignored
    press(0); press(1); press(0); press(1); press(0); // RUN, LAP, LAP_PAUSE, PAUSE, RUN
    press(2);                             // both together: PAUSE
    press(0);                             // RUN
    for (int i = 0; i < 10; i++) cyc(1, 0, i == DT + 2);
    idle(4);
    press(0);                             // ignored in OVF
    for (int i = 0; i < 5; i++) cyc(0, 0, 1);
    press(1);                             // OVF -> IDLE with clear
    cyc(1, 0, 0); cyc(1, 0, 0);
    async_reset_check();
    idle(2);
    rst_drive = 0;
    idle(3);
    lvl[0] = 0; lvl[1] = 0; left[0] = 0; left[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 2; b++) begin
        if (left[b] == 0) begin
          lvl[b]  = ($urandom_range(0, 2) == 0) ? 1 : 0;
          left[b] = $urandom_range(1, 9);
        end
        left[b]--;
      end
      ovv = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) rst_drive = 1;
      else rst_drive = 0;
      cyc(lvl[0] != 0, lvl[1] != 0, ovv);
    end
    rst_drive = 0;
    idle(4);
    @(posedge CLK_100Hz);
    #3;
    done = 1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
